// File: rtl/mem_dump_engine_pkg.sv
// Shared types and constants for the memory-dump sequencer.
package mem_dump_engine_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DONE
    } dump_state_t;

    // Word reported in place of RAM data when a read never completes.
    localparam logic [31:0] DUMP_BADWORD = 32'hBAADF00D;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_dump_engine_if.sv
// RAM read port plus the outgoing dump stream; master is the engine side.
interface mem_dump_engine_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);

    logic              mem_owner;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ren;
    logic [WORD_W-1:0] ram_load;
    logic              ram_ready;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [WORD_W-1:0] dump_data;

    modport master (
        output mem_owner,
        output ram_addr,
        output ram_ren,
        input  ram_load,
        input  ram_ready,
        output dump_valid,
        input  dump_ready,
        output dump_addr,
        output dump_data
    );

    modport slave (
        input  mem_owner,
        input  ram_addr,
        input  ram_ren,
        output ram_load,
        output ram_ready,
        input  dump_valid,
        output dump_ready,
        input  dump_addr,
        input  dump_data
    );

endinterface

// File: rtl/mem_dump_engine.sv
// Walks a RAM window one word at a time once started and streams each word out
// as addr/data on a valid/ready channel, owning the RAM port while busy.
module mem_dump_engine
    import mem_dump_engine_pkg::*;
#(
    parameter int              WORD_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              NUM_WORDS = 1500,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              STRIDE    = 4,
    parameter int              TIMEOUT   = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    mem_dump_engine_if.master bus
);

    localparam int CNT_W  = cnt_width(NUM_WORDS);
    localparam int WAIT_W = cnt_width(TIMEOUT);

    dump_state_t       state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;

    // The wait counter expiring and ram_ready arriving on the same edge still takes the real data.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state          <= IDLE;
            addr_q         <= BASE_ADDR;
            cnt            <= '0;
            wait_cnt       <= '0;
            err            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.mem_owner  <= 1'b0;
            bus.ram_ren    <= 1'b0;
            bus.ram_addr   <= '0;
            bus.dump_valid <= 1'b0;
            bus.dump_addr  <= '0;
            bus.dump_data  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= REQ;
                        addr_q        <= BASE_ADDR;
                        cnt           <= '0;
                        wait_cnt      <= '0;
                        err           <= 1'b0;
                        done          <= 1'b0;
                        busy          <= 1'b1;
                        bus.mem_owner <= 1'b1;
                        bus.ram_ren   <= 1'b1;
                        bus.ram_addr  <= BASE_ADDR;
                    end
                end
                REQ: begin
                    if (bus.ram_ready || (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
                        state          <= HOLD;
                        bus.ram_ren    <= 1'b0;
                        bus.ram_addr   <= '0;
                        bus.dump_valid <= 1'b1;
                        bus.dump_addr  <= addr_q;
                        if (bus.ram_ready) begin
                            bus.dump_data <= bus.ram_load;
                        end else begin
                            bus.dump_data <= WORD_W'(DUMP_BADWORD);
                            err           <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.dump_ready) begin
                        bus.dump_valid <= 1'b0;
                        bus.dump_addr  <= '0;
                        bus.dump_data  <= '0;
                        if (cnt == CNT_W'(NUM_WORDS - 1)) begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            bus.mem_owner <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            state        <= REQ;
                            addr_q       <= addr_q + ADDR_W'(STRIDE);
                            cnt          <= cnt + CNT_W'(1);
                            wait_cnt     <= '0;
                            bus.ram_ren  <= 1'b1;
                            bus.ram_addr <= addr_q + ADDR_W'(STRIDE);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Randomized bench for mem_dump_engine: per-word read latency and stream
// backpressure are drawn at random and each word is predicted from the dump rules.
module tb_mem_dump_engine;
   import mem_dump_engine_pkg::*;

   localparam int NW  = 4;
   localparam int TMO = 8;
   localparam int STR = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

   logic CLK;
   logic nRST;
   logic start;
   logic wstart;
   logic busy, done, err;
   logic wbusy, wdone, werr;
   logic [31:0] salt;

   int nChecks = 0;
   int nFails  = 0;
   int lat [NW];
   int bp  [NW];

   mem_dump_engine_if #(.ADDR_W(32), .WORD_W(32)) bus ();
   mem_dump_engine_if #(.ADDR_W(32), .WORD_W(32)) wbus ();

   mem_dump_engine #(
      .WORD_W(32), .ADDR_W(32), .NUM_WORDS(NW), .BASE_ADDR(BASE),
      .STRIDE(STR), .TIMEOUT(TMO)
   ) dut (
      .CLK(CLK), .nRST(nRST), .start(start),
      .busy(busy), .done(done), .err(err), .bus(bus.master)
   );

   mem_dump_engine #(
      .WORD_W(32), .ADDR_W(32), .NUM_WORDS(3), .BASE_ADDR(WBASE),
      .STRIDE(STR), .TIMEOUT(TMO)
   ) dutWrap (
      .CLK(CLK), .nRST(nRST), .start(wstart),
      .busy(wbusy), .done(wdone), .err(werr), .bus(wbus.master)
   );

   // RAM contents are a pure function of the word address, optionally scrambled per run.
   function automatic logic [31:0] ramWord(input logic [31:0] a, input logic [31:0] s);
      return ((a >> 2) * 32'd3) ^ s;
   endfunction

   // The wrap instance sees a zero-wait RAM and a consumer that is always ready.
   assign wbus.ram_ready  = wbus.ram_ren;
   assign wbus.ram_load   = ramWord(wbus.ram_addr, 32'h0);
   assign wbus.dump_ready = 1'b1;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge CLK);
      #1;
   endtask

   // Runs one dump on the main instance using lat[]/bp[]; lat >= TMO means RAM never answers.
   task automatic applyStimulus(input bit holdStart, input int abortWord);
      logic [31:0] a;
      logic [31:0] expData;
      int          reqCycles;
      bit          anyTmo;
      anyTmo = 1'b0;
      start = 1'b1;
      stepCycle();
      start = holdStart;
      checkOutput("start_done", 64'(done), 64'(0));
      checkOutput("start_err", 64'(err), 64'(0));
      for (int w = 0; w < NW; w++) begin
         a         = BASE + 32'(w * STR);
         reqCycles = (lat[w] < TMO) ? lat[w] + 1 : TMO;
         expData   = (lat[w] < TMO) ? ramWord(a, salt) : DUMP_BADWORD;
         for (int k = 0; k < reqCycles; k++) begin
            checkOutput("req_ren", 64'(bus.ram_ren), 64'(1));
            checkOutput("req_addr", 64'(bus.ram_addr), 64'(a));
            checkOutput("req_valid", 64'(bus.dump_valid), 64'(0));
            checkOutput("req_busy_owner", 64'({busy, bus.mem_owner}), 64'(2'b11));
            bus.ram_ready = (k == lat[w]);
            bus.ram_load  = bus.ram_ready ? ramWord(a, salt) : $urandom();
            stepCycle();
         end
         if (lat[w] >= TMO) anyTmo = 1'b1;
         bus.ram_ready = 1'b0;
         bus.ram_load  = $urandom();
         checkOutput("hold_valid", 64'(bus.dump_valid), 64'(1));
         checkOutput("hold_addr", 64'(bus.dump_addr), 64'(a));
         checkOutput("hold_data", 64'(bus.dump_data), 64'(expData));
         checkOutput("hold_ren", 64'(bus.ram_ren), 64'(0));
         checkOutput("hold_err", 64'(err), 64'(anyTmo));
         if (w == abortWord) begin
            nRST = 1'b0;
            start = 1'b0;
            bus.dump_ready = 1'b0;
            stepCycle();
            checkOutput("rst_flags", 64'({busy, done, err, bus.mem_owner, bus.ram_ren, bus.dump_valid}), 64'(0));
            checkOutput("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
            checkOutput("rst_dump_addr", 64'(bus.dump_addr), 64'(0));
            checkOutput("rst_dump_data", 64'(bus.dump_data), 64'(0));
            nRST = 1'b1;
            return;
         end
         for (int b = 0; b < bp[w]; b++) begin
            bus.dump_ready = 1'b0;
            stepCycle();
            checkOutput("bp_valid", 64'(bus.dump_valid), 64'(1));
            checkOutput("bp_addr", 64'(bus.dump_addr), 64'(a));
            checkOutput("bp_data", 64'(bus.dump_data), 64'(expData));
            checkOutput("bp_ren", 64'(bus.ram_ren), 64'(0));
         end
         bus.dump_ready = 1'b1;
         stepCycle();
         bus.dump_ready = 1'($urandom_range(0, 1));
      end
      checkOutput("end_done", 64'(done), 64'(1));
      checkOutput("end_busy_owner", 64'({busy, bus.mem_owner}), 64'(0));
      checkOutput("end_valid_ren", 64'({bus.dump_valid, bus.ram_ren}), 64'(0));
      checkOutput("end_err", 64'(err), 64'(anyTmo));
      if (!holdStart) begin
         stepCycle();
         checkOutput("done_held", 64'(done), 64'(1));
         checkOutput("err_held", 64'(err), 64'(anyTmo));
         checkOutput("done_idle_busy", 64'(busy), 64'(0));
      end
   endtask

   task automatic setLat(input int l0, input int l1, input int l2, input int l3);
      lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
   endtask

   task automatic setBp(input int b0, input int b1, input int b2, input int b3);
      bp[0] = b0; bp[1] = b1; bp[2] = b2; bp[3] = b3;
   endtask

   initial begin
      logic [31:0] wAddrQ [$];
      logic [31:0] wDataQ [$];
      logic [31:0] wExp [3];
      bit          hs;
      int          ab;

      nRST = 1'b0;
      start = 1'b0;
      wstart = 1'b0;
      salt = 32'h0;
      bus.ram_ready = 1'b0;
      bus.ram_load = '0;
      bus.dump_ready = 1'b0;
      repeat (2) stepCycle();
      checkOutput("reset_flags", 64'({busy, done, err, bus.mem_owner, bus.ram_ren, bus.dump_valid}), 64'(0));
      checkOutput("reset_ram_addr", 64'(bus.ram_addr), 64'(0));
      checkOutput("reset_dump_addr", 64'(bus.dump_addr), 64'(0));
      checkOutput("reset_dump_data", 64'(bus.dump_data), 64'(0));
      checkOutput("reset_wrap_flags", 64'({wbusy, wdone, werr, wbus.ram_addr}), 64'(0));
      nRST = 1'b1;
      stepCycle();
      checkOutput("idle_no_start", 64'({busy, done, bus.ram_ren}), 64'(0));

      $display("[TB] basic dump");
      setLat(0, 0, 0, 0); setBp(0, 0, 0, 0);
      applyStimulus(1'b0, -1);

      $display("[TB] backpressure on word 2");
      setBp(0, 0, 5, 0);
      applyStimulus(1'b0, -1);

      $display("[TB] wait states and timeout");
      salt = $urandom();
      setLat(3, 100, 0, 0); setBp(0, 0, 0, 0);
      applyStimulus(1'b0, -1);

      $display("[TB] ready coinciding with timeout");
      setLat(TMO - 1, TMO, 1, TMO - 1); setBp(1, 0, 2, 0);
      applyStimulus(1'b0, -1);

      $display("[TB] reset in hold of word 2, then restart");
      setLat(0, TMO + 3, 2, 0); setBp(0, 0, 0, 0);
      applyStimulus(1'b0, 2);
      setLat(1, 0, 0, 2);
      applyStimulus(1'b0, -1);

      $display("[TB] start held through run, then restart");
      setLat(0, TMO, 0, 0); setBp(0, 1, 0, 0);
      applyStimulus(1'b1, -1);
      setLat(0, 0, 0, 0); setBp(0, 0, 0, 0);
      applyStimulus(1'b0, -1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 25; r++) begin
         salt = $urandom();
         for (int w = 0; w < NW; w++) begin
            lat[w] = $urandom_range(0, TMO + 2);
            bp[w]  = $urandom_range(0, 3);
         end
         hs = (r < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
         applyStimulus(hs, ab);
      end
      start = 1'b0;

      $display("[TB] address wrap");
      wExp[0] = 32'hFFFF_FFF8;
      wExp[1] = 32'hFFFF_FFFC;
      wExp[2] = 32'h0000_0000;
      wstart = 1'b1;
      stepCycle();
      wstart = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (wbus.dump_valid) begin
            wAddrQ.push_back(wbus.dump_addr);
            wDataQ.push_back(wbus.dump_data);
         end
         if (wdone) break;
         stepCycle();
      end
      checkOutput("wrap_count", 64'(wAddrQ.size()), 64'(3));
      for (int i = 0; i < 3; i++) begin
         if (i < wAddrQ.size()) begin
            checkOutput("wrap_addr", 64'(wAddrQ[i]), 64'(wExp[i]));
            checkOutput("wrap_data", 64'(wDataQ[i]), 64'(ramWord(wExp[i], 32'h0)));
         end
      end
      checkOutput("wrap_done_err", 64'({wdone, werr}), 64'(2'b10));

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
